mmio_bus_arbiter: RTL

- Shares the single MMIO device port (switches, ROM, LEDs, seg7, UART mux) between two requesters.
- Requester M0 is the CPU load/store path; M1 is the debug/boot-loader master.
- Grants one transaction at a time and holds the grant until the device mux returns done or a timeout fires.
- Registers all downstream request signals and returns a one-cycle done pulse, with read data and error flag, to the granted master.

---
 rtl/mmio_bus_arbiter_pkg.sv | 20 ++
 rtl/mmio_bus_arbiter_if.sv | 44 ++++
 rtl/mmio_bus_arbiter_rr_pick.sv | 22 ++
 rtl/mmio_bus_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared types and constants for the two-master MMIO arbiter.
// Holds the FSM encoding, the default timeout read data and the MMIO window base.
package mmio_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam logic [31:0] MMIO_BASE        = 32'hFFFF_0000;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mmio_req_t;

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// Bundle of both requester ports and the downstream device port of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mmio_bus_arbiter_if;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_addr;
    logic [31:0] m0_write_data;
    logic        m0_done;
    logic [31:0] m0_read_data;
    logic        m0_err;

    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_addr;
    logic [31:0] m1_write_data;
    logic        m1_done;
    logic [31:0] m1_read_data;
    logic        m1_err;

    logic        mmio_read;
    logic        mmio_write;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_write_data;
    logic        mmio_done;
    logic [31:0] mmio_read_data;

    modport slave (
        input  m0_read, m0_write, m0_addr, m0_write_data,
        output m0_done, m0_read_data, m0_err,
        input  m1_read, m1_write, m1_addr, m1_write_data,
        output m1_done, m1_read_data, m1_err,
        output mmio_read, mmio_write, mmio_addr, mmio_write_data,
        input  mmio_done, mmio_read_data
    );

    modport master (
        output m0_read, m0_write, m0_addr, m0_write_data,
        input  m0_done, m0_read_data, m0_err,
        output m1_read, m1_write, m1_addr, m1_write_data,
        input  m1_done, m1_read_data, m1_err,
        input  mmio_read, mmio_write, mmio_addr, mmio_write_data,
        output mmio_done, mmio_read_data
    );
endinterface

// File: rtl/mmio_bus_arbiter_rr_pick.sv
// Two-way round-robin picker: on a tie, grants the master that was not granted last.
// Purely combinational; grant_o is one-hot, bit 0 = M0.
module mmio_bus_arbiter_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       valid_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Shares one MMIO device port between M0 (CPU) and M1 (debug), one transaction at a time.
// Define MMIO_ARB_FIXED_PRIO_EN for fixed priority (M0 wins ties); default is round-robin.
// state | meaning
// IDLE  | waiting for a request; latches the winner's op/addr/wdata
// BUSY  | strobes held; waits for mmio_done or the timeout count
// RESP  | one-cycle done pulse with read data and err to the granted master
module mmio_bus_arbiter
    import mmio_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                sys_clk,
    input  logic                rst,
    mmio_bus_arbiter_if.slave   bus
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    mmio_req_t        req_q, req_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [1:0]       req;
    logic [1:0]       grant;
    logic             grant_valid;
    mmio_req_t        win_req;

    assign req = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};

`ifdef MMIO_ARB_FIXED_PRIO_EN
    assign grant       = req[0] ? 2'b01 : {req[1], 1'b0};
    assign grant_valid = |req;
`else
    logic last_grant_q, last_grant_d;

    mmio_bus_arbiter_rr_pick u_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .valid_o      (grant_valid)
    );

    assign last_grant_d = (state_q == IDLE && grant_valid) ? grant[1] : last_grant_q;

    // Reset value 1 makes M0 win the first tie.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) last_grant_q <= 1'b1;
        else     last_grant_q <= last_grant_d;
    end
`endif

    // A request with both read and write high is treated as a write.
    assign win_req = grant[1] ? '{write: bus.m1_write, addr: bus.m1_addr, wdata: bus.m1_write_data}
                              : '{write: bus.m0_write, addr: bus.m0_addr, wdata: bus.m0_write_data};

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            req_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        req_d   = req_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                if (grant_valid) begin
                    state_d = BUSY;
                    sel_d   = grant[1];
                    req_d   = win_req;
                    rd_d    = ~win_req.write;
                    wr_d    = win_req.write;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (bus.mmio_done) begin
                    state_d = RESP;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rdata_d = req_q.write ? 32'h0 : bus.mmio_read_data;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.m0_done      = (state_q == RESP) && !sel_q;
        bus.m1_done      = (state_q == RESP) &&  sel_q;
        bus.m0_read_data = bus.m0_done ? rdata_q : 32'h0;
        bus.m1_read_data = bus.m1_done ? rdata_q : 32'h0;
        bus.m0_err       = bus.m0_done & err_q;
        bus.m1_err       = bus.m1_done & err_q;
    end

    assign bus.mmio_read       = rd_q;
    assign bus.mmio_write      = wr_q;
    assign bus.mmio_addr       = req_q.addr;
    assign bus.mmio_write_data = req_q.wdata;

endmodule
